sd_fifo_rx_filler: RTL and testbench

Receive-side counterpart of the SD TX filler: accepts 32-bit words from the SD data path into an internal FIFO and drains them to system memory as Wishbone master single writes. Destination address is a base address plus an auto-incrementing byte offset. Sits between the SD data receiver (already synchronized to `clk`) and the Wishbone master port of the SD controller.

---
 rtl/sd_fifo_rx_filler_pkg.sv | 19 +
 rtl/sd_fifo_rx_filler_if.sv | 33 +++
 rtl/sd_fifo_rx_filler_sync_fifo.sv | 49 ++++
 rtl/sd_fifo_rx_filler.sv | 97 +++++++++
 tb/tb_sd_fifo_rx_filler.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sd_fifo_rx_filler_pkg.sv
// Shared types and constants for the SD FIFO fillers.
// Byte-swap helper backs the SD_RX_FILLER_BYTE_SWAP_EN build option.
package sd_fifo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } rx_fill_state_t;

    localparam logic [3:0] SD_WB_SEL_ALL = 4'hF;
    localparam int SD_FIFO_DEPTH_DEFAULT = 16;

    function automatic logic [31:0] sd_bswap32(
        input logic [31:0] w
    );
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/sd_fifo_rx_filler_if.sv
// Wishbone master write port of the SD RX filler.
// Single-clock classic Wishbone subset: single writes only.
interface sd_fifo_rx_filler_if;

    logic [31:0] m_wb_adr_o;
    logic [31:0] m_wb_dat_o;
    logic        m_wb_we_o;
    logic        m_wb_cyc_o;
    logic        m_wb_stb_o;
    logic [3:0]  m_wb_sel_o;
    logic        m_wb_ack_i;

    modport master (
        output m_wb_adr_o,
        output m_wb_dat_o,
        output m_wb_we_o,
        output m_wb_cyc_o,
        output m_wb_stb_o,
        output m_wb_sel_o,
        input  m_wb_ack_i
    );

    modport slave (
        input  m_wb_adr_o,
        input  m_wb_dat_o,
        input  m_wb_we_o,
        input  m_wb_cyc_o,
        input  m_wb_stb_o,
        input  m_wb_sel_o,
        output m_wb_ack_i
    );

endinterface

// File: rtl/sd_fifo_rx_filler_sync_fifo.sv
// Single-clock FIFO with synchronous flush, shared by the SD TX and RX fillers.
// Full/empty come from read/write pointers carrying one extra wrap bit.
module sd_sync_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] dat_i,
    output logic [W-1:0] dat_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wptr_q;
    logic [AW:0]  rptr_q;
    logic         push_ok;
    logic         pop_ok;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    // A simultaneous pop frees the slot, so a push into a full FIFO is kept.
    assign push_ok = push_i && (!full_o || pop_i);
    assign pop_ok  = pop_i && !empty_o;
    assign dat_o   = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop_ok)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush_i) mem_q[wptr_q[AW-1:0]] <= dat_i;
    end

endmodule

// File: rtl/sd_fifo_rx_filler.sv
// SD RX filler: buffers SD words and writes them to memory over Wishbone.
// Define SD_RX_FILLER_BYTE_SWAP_EN to byte-reverse each word on the bus.
module sd_fifo_rx_filler
    import sd_fifo_pkg::*;
#(
    parameter int FIFO_DEPTH = SD_FIFO_DEPTH_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [31:0]                 adr,
    input  logic                        wr,
    input  logic [31:0]                 dat_i,
    sd_fifo_rx_filler_if.master         wb,
    output logic                        full,
    output logic                        empty,
    output logic                        overflow
);

    rx_fill_state_t state_q;
    logic [31:0]    adr_q;
    logic [31:0]    dat_q;
    logic           cyc_q;
    logic [31:0]    off_q;
    logic           ovf_q;
    logic [31:0]    head;
    logic [31:0]    wdat;
    logic           pop;

    assign pop = (state_q == IDLE) && en && !empty;

`ifdef SD_RX_FILLER_BYTE_SWAP_EN
    assign wdat = sd_bswap32(head);
`else
    assign wdat = head;
`endif

    sd_sync_fifo #(
        .W     (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .flush_i (!en),
        .push_i  (wr && en),
        .pop_i   (pop),
        .dat_i   (dat_i),
        .dat_o   (head),
        .full_o  (full),
        .empty_o (empty)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            adr_q   <= '0;
            dat_q   <= '0;
            cyc_q   <= 1'b0;
            off_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pop) begin
                        adr_q   <= adr + off_q;
                        dat_q   <= wdat;
                        cyc_q   <= 1'b1;
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    if (wb.m_wb_ack_i) begin
                        cyc_q   <= 1'b0;
                        state_q <= IDLE;
                        if (en) off_q <= off_q + 32'd4;
                    end
                end
                default: state_q <= IDLE;
            endcase
            // Disabling restarts the buffer at its base, even mid-transfer.
            if (!en) off_q <= '0;
            if (!en)
                ovf_q <= 1'b0;
            else if (wr && full && !pop)
                ovf_q <= 1'b1;
        end
    end

    assign wb.m_wb_adr_o = adr_q;
    assign wb.m_wb_dat_o = dat_q;
    assign wb.m_wb_cyc_o = cyc_q;
    assign wb.m_wb_stb_o = cyc_q;
    assign wb.m_wb_we_o  = cyc_q;
    assign wb.m_wb_sel_o = SD_WB_SEL_ALL;
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_sd_fifo_rx_filler.sv
// Randomized and directed bench for sd_fifo_rx_filler.
// A queue-based transaction model predicts every bus cycle and flag.
module tb_sd_fifo_rx_filler;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [31:0] adr = '0;
    logic        wr = 1'b0;
    logic [31:0] dat_i = '0;
    logic        full;
    logic        empty;
    logic        overflow;

    sd_fifo_rx_filler_if wb ();

    sd_fifo_rx_filler #(
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .adr      (adr),
        .wr       (wr),
        .dat_i    (dat_i),
        .wb       (wb.master),
        .full     (full),
        .empty    (empty),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int ack_mode = 0;

    logic [31:0] m_q[$];
    logic        m_busy;
    logic [31:0] m_adr;
    logic [31:0] m_dat;
    logic [31:0] m_off;
    logic        m_ovf;
    logic [31:0] wa[$];
    logic [31:0] wd[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [31:0] w);
`ifdef SD_RX_FILLER_BYTE_SWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    // One clock edge of the reference: retire, issue, then enqueue.
    task automatic model_edge();
        logic ack;
        ack = wb.m_wb_ack_i;
        if (!rst) begin
            m_q.delete();
            m_busy = 1'b0;
            m_adr = '0;
            m_dat = '0;
            m_off = '0;
            m_ovf = 1'b0;
            return;
        end
        if (m_busy) begin
            if (ack) begin
                wa.push_back(m_adr);
                wd.push_back(m_dat);
                m_busy = 1'b0;
                m_off = m_off + 32'd4;
            end
        end else if (en && m_q.size() > 0) begin
            m_dat = exp_word(m_q.pop_front());
            m_adr = adr + m_off;
            m_busy = 1'b1;
        end
        if (!en) begin
            m_off = '0;
            m_ovf = 1'b0;
            m_q.delete();
        end else if (wr) begin
            if (m_q.size() < DEPTH) m_q.push_back(dat_i);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic step();
        case (ack_mode)
            0: wb.m_wb_ack_i = 1'b0;
            1: wb.m_wb_ack_i = m_busy;
            default: wb.m_wb_ack_i = ($urandom_range(0, 2) == 0);
        endcase
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("cyc", 32'(wb.m_wb_cyc_o), 32'(m_busy));
        chk("stb", 32'(wb.m_wb_stb_o), 32'(m_busy));
        chk("we", 32'(wb.m_wb_we_o), 32'(m_busy));
        chk("sel", 32'(wb.m_wb_sel_o), 32'hF);
        chk("adr", wb.m_wb_adr_o, m_adr);
        chk("dat", wb.m_wb_dat_o, m_dat);
        chk("empty", 32'(empty), 32'(m_q.size() == 0));
        chk("full", 32'(full), 32'(m_q.size() == DEPTH));
        chk("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic push(input logic [31:0] w);
        wr = 1'b1;
        dat_i = w;
        step();
        wr = 1'b0;
    endtask

    task automatic idle(input int n);
        wr = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    // Drain in-flight work, then pulse en low so offset restarts at 0.
    task automatic fresh(input logic [31:0] base);
        ack_mode = 1;
        en = 1'b1;
        idle(4 * DEPTH + 8);
        en = 1'b0;
        idle(1);
        adr = base;
        en = 1'b1;
        wa.delete();
        wd.delete();
    endtask

    initial begin
        wb.m_wb_ack_i = 1'b0;
        m_q.delete();
        m_busy = 1'b0;
        m_adr = '0;
        m_dat = '0;
        m_off = '0;
        m_ovf = 1'b0;

        // Reset with pushes asserted.
        rst = 1'b0;
        wr = 1'b1;
        dat_i = 32'hDEAD_BEEF;
        en = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_cyc", 32'(wb.m_wb_cyc_o), 32'd0);
        wr = 1'b0;
        rst = 1'b1;

        // Basic drain.
        fresh(32'h0000_1000);
        for (int i = 0; i < 4; i++) push(32'hA000_0000 + 32'(i));
        idle(20);
        chk("basic_n", 32'(wa.size()), 32'd4);
        for (int i = 0; i < 4 && i < wa.size(); i++) begin
            chk("basic_adr", wa[i], 32'h0000_1000 + 32'(4 * i));
            chk("basic_dat", wd[i], exp_word(32'hA000_0000 + 32'(i)));
        end
        chk("basic_empty", 32'(empty), 32'd1);

        // Overflow: one word sits on the bus, DEPTH fill the FIFO, last drops.
        fresh(32'h0000_3000);
        ack_mode = 0;
        for (int i = 0; i < DEPTH + 2; i++) push(32'hB000_0000 + 32'(i));
        chk("ovf_full", 32'(full), 32'd1);
        chk("ovf_flag", 32'(overflow), 32'd1);
        ack_mode = 1;
        idle(4 * DEPTH + 8);
        chk("ovf_n", 32'(wa.size()), 32'(DEPTH + 1));
        if (wa.size() == DEPTH + 1) begin
            chk("ovf_last", wd[DEPTH], exp_word(32'hB000_0000 + 32'(DEPTH)));
            chk("ovf_ladr", wa[DEPTH], 32'h0000_3000 + 32'(4 * DEPTH));
        end

        // Address wrap.
        fresh(32'hFFFF_FFF8);
        for (int i = 0; i < 3; i++) push(32'hC000_0000 + 32'(i));
        idle(12);
        chk("wrap_n", 32'(wa.size()), 32'd3);
        if (wa.size() == 3) begin
            chk("wrap_a0", wa[0], 32'hFFFF_FFF8);
            chk("wrap_a1", wa[1], 32'hFFFF_FFFC);
            chk("wrap_a2", wa[2], 32'h0000_0000);
        end

        // Enable dropped while a write is outstanding.
        fresh(32'h0000_2000);
        ack_mode = 0;
        for (int i = 0; i < 4; i++) push(32'hD000_0000 + 32'(i));
        en = 1'b0;
        idle(2);
        ack_mode = 1;
        idle(3);
        chk("endrop_n", 32'(wa.size()), 32'd1);
        chk("endrop_empty", 32'(empty), 32'd1);
        en = 1'b1;
        push(32'hD000_00FF);
        idle(6);
        chk("endrop_n2", 32'(wa.size()), 32'd2);
        if (wa.size() == 2) begin
            chk("endrop_adr", wa[1], 32'h0000_2000);
            chk("endrop_dat", wd[1], exp_word(32'hD000_00FF));
        end

        // Byte order of a known pattern.
        fresh(32'h0000_4000);
        push(32'h1122_3344);
        idle(1);
`ifdef SD_RX_FILLER_BYTE_SWAP_EN
        chk("swap_dat", wb.m_wb_dat_o, 32'h4433_2211);
`else
        chk("swap_dat", wb.m_wb_dat_o, 32'h1122_3344);
`endif
        idle(6);

        // Random traffic, random acks, occasional disable and reset.
        ack_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) != 0);
            en = ($urandom_range(0, 39) != 0);
            wr = $urandom_range(0, 1) == 1;
            dat_i = $urandom;
            if ($urandom_range(0, 99) == 0) adr = $urandom;
            step();
        end
        rst = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
